// File: rtl/free_list.sv
// free_list: circular FIFO of free physical register IDs for the rename stage.
// Rename pops up to RENAME_WIDTH pregs per cycle, compacted across the requesting
// lanes. Commit pushes back up to COMMIT_WIDTH superseded pregs. A committed head
// pointer lets a flush reclaim every speculative allocation in one cycle.
// Optional feature macro: FREELIST_DBL_FREE_CHECK_EN adds the in_list tracking
// vector and drives a sticky dbl_free_err output.
module free_list #(
    parameter  int NUM_PREGS    = 64,
    parameter  int NUM_AREGS    = 32,
    parameter  int RENAME_WIDTH = 2,
    parameter  int COMMIT_WIDTH = 2,
    localparam int PW           = $clog2(NUM_PREGS),
    localparam int FL_DEPTH     = NUM_PREGS - NUM_AREGS,
    localparam int CW           = $clog2(FL_DEPTH) + 1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [RENAME_WIDTH-1:0]             alloc_req,
    output logic [RENAME_WIDTH-1:0][PW-1:0]     alloc_preg,
    output logic                                alloc_ready,
    input  logic [COMMIT_WIDTH-1:0]             commit_valid,
    input  logic [COMMIT_WIDTH-1:0][PW-1:0]     commit_old_preg,
    input  logic                                flush,
    output logic [CW-1:0]                       free_count,
    output logic                                dbl_free_err
);

    localparam int IW = CW - 1;

    logic [PW-1:0]           mem_q [FL_DEPTH];
    logic [PW-1:0]           mem_d [FL_DEPTH];
    logic [CW-1:0]           head_q, head_d;
    logic [CW-1:0]           tail_q, tail_d;
    logic [CW-1:0]           commit_head_q, commit_head_d;
    logic [CW-1:0]           alloc_offs;
    logic [CW-1:0]           alloc_cnt;
    logic [IW-1:0]           rd_idx;
    logic [CW-1:0]           occ;
    logic [CW-1:0]           wr_ptr;
    logic [COMMIT_WIDTH-1:0] commit_acc;
    logic                    take_alloc;

    // Occupancy and readiness come only from registered pointers.
    assign free_count  = tail_q - head_q;
    assign alloc_ready = (free_count >= CW'(RENAME_WIDTH));
    assign take_alloc  = alloc_ready && !flush;

    // Offer compacted entries to the requesting lanes, starting at head.
    always_comb begin
        alloc_offs = '0;
        rd_idx     = '0;
        for (int k = 0; k < RENAME_WIDTH; k++) begin
            rd_idx        = head_q[IW-1:0] + alloc_offs[IW-1:0];
            alloc_preg[k] = mem_q[rd_idx];
            alloc_offs    = alloc_offs + CW'(alloc_req[k]);
        end
        alloc_cnt = alloc_offs;
    end

    // Accept commit lanes in order while the list has room; the rest are dropped.
    always_comb begin
        occ        = tail_q - head_q;
        commit_acc = '0;
        for (int j = 0; j < COMMIT_WIDTH; j++) begin
            if (commit_valid[j] && (occ < CW'(FL_DEPTH))) begin
                commit_acc[j] = 1'b1;
                occ           = occ + 1'b1;
            end
        end
    end

    // Next state: write accepted frees at tail, then move head for alloc or flush.
    always_comb begin
        mem_d  = mem_q;
        wr_ptr = tail_q;
        for (int j = 0; j < COMMIT_WIDTH; j++) begin
            if (commit_acc[j]) begin
                mem_d[wr_ptr[IW-1:0]] = commit_old_preg[j];
                wr_ptr                = wr_ptr + 1'b1;
            end
        end
        tail_d        = wr_ptr;
        commit_head_d = commit_head_q + (wr_ptr - tail_q);
        head_d        = head_q;
        if (flush) begin
            head_d = commit_head_d;
        end else if (take_alloc) begin
            head_d = head_q + alloc_cnt;
        end
    end

    // Pointer and storage registers; reset loads pregs NUM_AREGS..NUM_PREGS-1.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < FL_DEPTH; i++) begin
                mem_q[i] <= PW'(NUM_AREGS + i);
            end
            head_q        <= '0;
            tail_q        <= CW'(FL_DEPTH);
            commit_head_q <= '0;
        end else begin
            mem_q         <= mem_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            commit_head_q <= commit_head_d;
        end
    end

`ifdef FREELIST_DBL_FREE_CHECK_EN
    logic [NUM_PREGS-1:0] in_list_q, in_list_d;
    logic                 dbl_q, dbl_d;
    logic [CW-1:0]        reclaim_cnt;
    logic [IW-1:0]        rm_idx;

    // Track which pregs sit in the list and flag frees that break the protocol.
    always_comb begin
        in_list_d   = in_list_q;
        dbl_d       = dbl_q;
        reclaim_cnt = head_q - commit_head_d;
        rm_idx      = '0;
        if (take_alloc) begin
            for (int k = 0; k < RENAME_WIDTH; k++) begin
                if (alloc_req[k]) begin
                    in_list_d[alloc_preg[k]] = 1'b0;
                end
            end
        end
        for (int j = 0; j < COMMIT_WIDTH; j++) begin
            if (commit_valid[j]) begin
                if (!commit_acc[j] || in_list_q[commit_old_preg[j]]) begin
                    dbl_d = 1'b1;
                end
                for (int m = 0; m < j; m++) begin
                    if (commit_valid[m] && (commit_old_preg[m] == commit_old_preg[j])) begin
                        dbl_d = 1'b1;
                    end
                end
                if (commit_acc[j]) begin
                    in_list_d[commit_old_preg[j]] = 1'b1;
                end
            end
        end
        if (flush) begin
            for (int i = 0; i < FL_DEPTH; i++) begin
                rm_idx = commit_head_d[IW-1:0] + IW'(i);
                if (CW'(i) < reclaim_cnt) begin
                    in_list_d[mem_q[rm_idx]] = 1'b1;
                end
            end
        end
    end

    // Membership vector and sticky error flag registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_PREGS; i++) begin
                in_list_q[i] <= (i >= NUM_AREGS);
            end
            dbl_q <= 1'b0;
        end else begin
            in_list_q <= in_list_d;
            dbl_q     <= dbl_d;
        end
    end

    assign dbl_free_err = dbl_q;
`else
    assign dbl_free_err = 1'b0;
`endif

endmodule
